// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow EXE/MEM/WB destination pipeline,
// load-use / RAW stall control, freeze on busy memory, stall counter.
module hazard_scoreboard #(
    parameter int REG_W              = 5,
    parameter bit ZERO_REG_HARDWIRED = 1'b0,
    parameter int CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid_ID,
    input  logic [REG_W-1:0] src1_ID,
    input  logic [REG_W-1:0] src2_ID,
    input  logic             use_src1_ID,
    input  logic             use_src2_ID,
    input  logic [REG_W-1:0] dest_ID,
    input  logic             wb_en_ID,
    input  logic             mem_read_ID,
    input  logic             forward_en,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             stall_ID,
    output logic             bubble_EXE,
    output logic             freeze,
    output logic [REG_W-1:0] dest_EXE,
    output logic [REG_W-1:0] dest_MEM,
    output logic [REG_W-1:0] dest_WB,
    output logic             wb_en_EXE,
    output logic             wb_en_MEM,
    output logic             wb_en_WB,
    output logic             mem_read_EXE,
    output logic [CNT_W-1:0] stall_cycles
);

    function automatic logic hit(
        input logic [REG_W-1:0] s,
        input logic             rd,
        input logic [REG_W-1:0] d,
        input logic             en
    );
        hit = rd && en && (s == d) &&
              !(ZERO_REG_HARDWIRED && (s == '0));
    endfunction

    logic hz_exe;
    logic hz_mem;
    logic issue_exe;

    // RAW match of both ID sources against the EXE and MEM shadows
    always_comb begin
        hz_exe = hit(src1_ID, use_src1_ID, dest_EXE, wb_en_EXE) ||
                 hit(src2_ID, use_src2_ID, dest_EXE, wb_en_EXE);
        hz_mem = hit(src1_ID, use_src1_ID, dest_MEM, wb_en_MEM) ||
                 hit(src2_ID, use_src2_ID, dest_MEM, wb_en_MEM);
    end

    assign stall_ID = issue_valid_ID && !flush &&
                      (forward_en ? (hz_exe && mem_read_EXE)
                                  : (hz_exe || hz_mem));
    assign bubble_EXE = stall_ID || flush;
    assign freeze     = !mem_ready;
    assign issue_exe  = issue_valid_ID && !bubble_EXE;

    // Shadow pipeline: advance unless memory is busy; bubbles carry wb_en=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_EXE     <= '0;
            dest_MEM     <= '0;
            dest_WB      <= '0;
            wb_en_EXE    <= 1'b0;
            wb_en_MEM    <= 1'b0;
            wb_en_WB     <= 1'b0;
            mem_read_EXE <= 1'b0;
        end else if (!freeze) begin
            dest_EXE     <= issue_exe ? dest_ID : '0;
            wb_en_EXE    <= issue_exe && wb_en_ID;
            mem_read_EXE <= issue_exe && mem_read_ID;
            dest_MEM     <= dest_EXE;
            wb_en_MEM    <= wb_en_EXE;
            dest_WB      <= dest_MEM;
            wb_en_WB     <= wb_en_MEM;
        end
    end

    // Saturating count of cycles in which ID really stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_ID && !freeze && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: cycle table with an expected-value
// queue, plus hand sequences for reset, x0 and counter saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iv;
    logic [4:0] s1, s2, d;
    logic       u1, u2, we, mr, fw, fl, rdy;

    logic        st, bu, fz, we_e, we_m, we_w, me;
    logic [4:0]  de, dm, dw;
    logic [15:0] cnt;

    logic        st2, bu2, fz2, we_e2, we_m2, we_w2, me2;
    logic [4:0]  de2, dm2, dw2;
    logic [1:0]  cnt2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .issue_valid_ID(iv),
        .src1_ID(s1), .src2_ID(s2),
        .use_src1_ID(u1), .use_src2_ID(u2),
        .dest_ID(d), .wb_en_ID(we), .mem_read_ID(mr),
        .forward_en(fw), .flush(fl), .mem_ready(rdy),
        .stall_ID(st), .bubble_EXE(bu), .freeze(fz),
        .dest_EXE(de), .dest_MEM(dm), .dest_WB(dw),
        .wb_en_EXE(we_e), .wb_en_MEM(we_m), .wb_en_WB(we_w),
        .mem_read_EXE(me), .stall_cycles(cnt)
    );

    hazard_scoreboard #(
        .REG_W(5), .ZERO_REG_HARDWIRED(1'b1), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .issue_valid_ID(iv),
        .src1_ID(s1), .src2_ID(s2),
        .use_src1_ID(u1), .use_src2_ID(u2),
        .dest_ID(d), .wb_en_ID(we), .mem_read_ID(mr),
        .forward_en(fw), .flush(fl), .mem_ready(rdy),
        .stall_ID(st2), .bubble_EXE(bu2), .freeze(fz2),
        .dest_EXE(de2), .dest_MEM(dm2), .dest_WB(dw2),
        .wb_en_EXE(we_e2), .wb_en_MEM(we_m2), .wb_en_WB(we_w2),
        .mem_read_EXE(me2), .stall_cycles(cnt2)
    );

    typedef struct {
        logic       iv;
        logic [4:0] s1, s2;
        logic       u1, u2;
        logic [4:0] d;
        logic       we, mr, fw, fl, rdy;
    } in_t;

    typedef struct {
        logic        st, bu, fz;
        logic [4:0]  de;
        logic        we;
        logic [4:0]  dm;
        logic        wm;
        logic [4:0]  dw;
        logic        ww, me;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic in_t I(int v, int a, int b, int ua, int ub,
                              int dd, int w, int m, int f,
                              int fl_, int r);
        in_t x;
        x.iv = 1'(v);   x.s1 = 5'(a);  x.s2 = 5'(b);
        x.u1 = 1'(ua);  x.u2 = 1'(ub); x.d  = 5'(dd);
        x.we = 1'(w);   x.mr = 1'(m);  x.fw = 1'(f);
        x.fl = 1'(fl_); x.rdy = 1'(r);
        return x;
    endfunction

    function automatic exp_t E(int s, int b, int z, int xde,
                               int xwe, int xdm, int xwm, int xdw,
                               int xww, int xme, int c);
        exp_t x;
        x.st = 1'(s);    x.bu = 1'(b);    x.fz = 1'(z);
        x.de = 5'(xde);  x.we = 1'(xwe);  x.dm = 5'(xdm);
        x.wm = 1'(xwm);  x.dw = 5'(xdw);  x.ww = 1'(xww);
        x.me = 1'(xme);  x.cnt = 16'(c);
        return x;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic apply(input in_t x);
        iv = x.iv; s1 = x.s1; s2 = x.s2; u1 = x.u1; u2 = x.u2;
        d = x.d; we = x.we; mr = x.mr; fw = x.fw; fl = x.fl;
        rdy = x.rdy;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic chk_row(input int r, input exp_t e);
        string p;
        p = $sformatf("row%0d", r);
        chk({p, " stall_ID"}, int'(st), int'(e.st));
        chk({p, " bubble_EXE"}, int'(bu), int'(e.bu));
        chk({p, " freeze"}, int'(fz), int'(e.fz));
        chk({p, " dest_EXE"}, int'(de), int'(e.de));
        chk({p, " wb_en_EXE"}, int'(we_e), int'(e.we));
        chk({p, " dest_MEM"}, int'(dm), int'(e.dm));
        chk({p, " wb_en_MEM"}, int'(we_m), int'(e.wm));
        chk({p, " dest_WB"}, int'(dw), int'(e.dw));
        chk({p, " wb_en_WB"}, int'(we_w), int'(e.ww));
        chk({p, " mem_read_EXE"}, int'(me), int'(e.me));
        chk({p, " stall_cycles"}, int'(cnt), int'(e.cnt));
    endtask

    initial begin
        in_t idle;
        in_t ldr;
        in_t use3;
        exp_t e;

        idle = I(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

        // reset / idle
        add(idle, E(0,0,0, 0,0, 0,0, 0,0, 0, 0));
        // load-use, forwarding on
        add(I(1,0,0,0,0,3,1,1,1,0,1), E(0,0,0, 0,0, 0,0, 0,0, 0, 0));
        add(I(1,3,0,1,0,4,1,0,1,0,1), E(1,1,0, 3,1, 0,0, 0,0, 1, 0));
        add(I(1,3,0,1,0,4,1,0,1,0,1), E(0,0,0, 0,0, 3,1, 0,0, 0, 1));
        add(idle,                     E(0,0,0, 4,1, 0,0, 3,1, 0, 1));
        // ALU RAW, forwarding on
        add(I(1,0,0,0,0,5,1,0,1,0,1), E(0,0,0, 0,0, 4,1, 0,0, 0, 1));
        add(I(1,1,5,1,1,6,1,0,1,0,1), E(0,0,0, 5,1, 0,0, 4,1, 0, 1));
        add(idle,                     E(0,0,0, 6,1, 5,1, 0,0, 0, 1));
        add(idle,                     E(0,0,0, 0,0, 6,1, 5,1, 0, 1));
        add(idle,                     E(0,0,0, 0,0, 0,0, 6,1, 0, 1));
        // ALU RAW, forwarding off: two stall cycles
        add(I(1,0,0,0,0,5,1,0,0,0,1), E(0,0,0, 0,0, 0,0, 0,0, 0, 1));
        add(I(1,1,5,0,1,6,1,0,0,0,1), E(1,1,0, 5,1, 0,0, 0,0, 0, 1));
        add(I(1,1,5,0,1,6,1,0,0,0,1), E(1,1,0, 0,0, 5,1, 0,0, 0, 2));
        add(I(1,1,5,0,1,6,1,0,0,0,1), E(0,0,0, 0,0, 0,0, 5,1, 0, 3));
        add(idle,                     E(0,0,0, 6,1, 0,0, 0,0, 0, 3));
        add(idle,                     E(0,0,0, 0,0, 6,1, 0,0, 0, 3));
        add(idle,                     E(0,0,0, 0,0, 0,0, 6,1, 0, 3));
        // freeze during a load-use stall
        add(I(1,0,0,0,0,7,1,1,1,0,1), E(0,0,0, 0,0, 0,0, 0,0, 0, 3));
        add(I(1,7,0,1,0,8,1,0,1,0,0), E(1,1,1, 7,1, 0,0, 0,0, 1, 3));
        add(I(1,7,0,1,0,8,1,0,1,0,0), E(1,1,1, 7,1, 0,0, 0,0, 1, 3));
        add(I(1,7,0,1,0,8,1,0,1,0,0), E(1,1,1, 7,1, 0,0, 0,0, 1, 3));
        add(I(1,7,0,1,0,8,1,0,1,0,1), E(1,1,0, 7,1, 0,0, 0,0, 1, 3));
        add(I(1,7,0,1,0,8,1,0,1,0,1), E(0,0,0, 0,0, 7,1, 0,0, 0, 4));
        add(idle,                     E(0,0,0, 8,1, 0,0, 7,1, 0, 4));
        add(idle,                     E(0,0,0, 0,0, 8,1, 0,0, 0, 4));
        add(idle,                     E(0,0,0, 0,0, 0,0, 8,1, 0, 4));
        // flush beats load-use; invalid ID never stalls
        add(I(1,0,0,0,0,9,1,1,1,0,1),  E(0,0,0, 0,0, 0,0, 0,0, 0, 4));
        add(I(1,9,0,1,0,10,1,0,1,1,1), E(0,1,0, 9,1, 0,0, 0,0, 1, 4));
        add(I(0,9,0,1,0,10,1,0,0,0,1), E(0,0,0, 0,0, 9,1, 0,0, 0, 4));
        add(idle,                      E(0,0,0, 0,0, 0,0, 9,1, 0, 4));
        // hazard on both sources costs one cycle
        add(I(1,0,0,0,0,11,1,1,1,0,1),   E(0,0,0, 0,0, 0,0, 0,0, 0, 4));
        add(I(1,11,11,1,1,12,1,0,1,0,1), E(1,1,0, 11,1, 0,0, 0,0, 1, 4));
        add(I(1,11,11,1,1,12,1,0,1,0,1), E(0,0,0, 0,0, 11,1, 0,0, 0, 5));
        add(idle,                        E(0,0,0, 12,1, 0,0, 11,1, 0, 5));
        add(idle,                        E(0,0,0, 0,0, 12,1, 0,0, 0, 5));
        add(idle,                        E(0,0,0, 0,0, 0,0, 12,1, 0, 5));

        apply(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[r]) begin
            @(posedge clk);
            #1;
            apply(tbl[r].i);
            exp_q.push_back(tbl[r].e);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("scoreboard empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk_row(r, e);
            end
        end
        chk("scoreboard drained", exp_q.size(), 0);

        // asynchronous reset in the middle of a load-use stall
        ldr  = I(1,0,0,0,0,3,1,1,1,0,1);
        use3 = I(1,3,0,1,0,4,1,0,1,0,1);
        @(posedge clk); #1 apply(ldr);
        @(posedge clk); #1 apply(use3);
        @(negedge clk);
        chk("pre-reset stall_ID", int'(st), 1);
        chk("pre-reset stall_cycles", int'(cnt), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid-reset stall_ID", int'(st), 0);
        chk("mid-reset bubble_EXE", int'(bu), 0);
        chk("mid-reset dest_EXE", int'(de), 0);
        chk("mid-reset wb_en_EXE", int'(we_e), 0);
        chk("mid-reset mem_read_EXE", int'(me), 0);
        chk("mid-reset stall_cycles", int'(cnt), 0);
        apply(idle);

        // load into x0: hazard only where x0 is not hardwired
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(I(1,0,0,0,0,0,1,1,1,0,1));
        @(posedge clk); #1 apply(I(1,0,0,1,0,1,1,0,1,0,1));
        @(negedge clk);
        chk("x0 dut2 dest_EXE", int'(de2), 0);
        chk("x0 dut2 wb_en_EXE", int'(we_e2), 1);
        chk("x0 dut2 mem_read_EXE", int'(me2), 1);
        chk("x0 hardwired stall_ID", int'(st2), 0);
        chk("x0 plain stall_ID", int'(st), 1);
        apply(idle);

        // back-to-back RAW without forwarding: 2-bit counter saturates
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply(I(1,2,0,1,0,2,1,0,0,0,1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat early cnt16", int'(cnt), 2);
        chk("sat early cnt2", int'(cnt2), 2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("sat cnt16", int'(cnt), 8);
        chk("sat cnt2", int'(cnt2), 3);
        apply(idle);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side counterpart of the EXE-stage forwarding selector. It tracks in-flight destination registers through EXE/MEM/WB in a shadow pipeline and exports those (dest, wb_en) pairs to the forwarding logic.
- It stalls ID on load-use hazards, or on any RAW hazard when forwarding is disabled. It also freezes the pipe while memory is busy.
- It sits beside the ID/EXE, EXE/MEM and MEM/WB pipeline registers.

Parameters:
- REG_W, 5, register-address width.
- ZERO_REG_HARDWIRED, 0, when 1, source address 0 never raises a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid_ID  in  1  a valid instruction is in ID.
- src1_ID  in  REG_W  first source register of the ID instruction.
- src2_ID  in  REG_W  second source register of the ID instruction.
- use_src1_ID  in  1  src1 is actually read.
- use_src2_ID  in  1  src2 is actually read (0 for immediate forms).
- dest_ID  in  REG_W  destination register of the ID instruction.
- wb_en_ID  in  1  ID instruction writes the register file.
- mem_read_ID  in  1  ID instruction is a load.
- forward_en  in  1  runtime mode: 1 = forwarding unit active.
- flush  in  1  taken branch resolved in EXE; kill the ID instruction.
- mem_ready  in  1  memory stage done this cycle; 0 = memory busy.
- stall_ID  out  1  hold PC and IF/ID register.
- bubble_EXE  out  1  load a NOP into ID/EXE.
- freeze  out  1  hold every pipeline register.
- dest_EXE, dest_MEM, dest_WB  out  REG_W  shadow destinations.
- wb_en_EXE, wb_en_MEM, wb_en_WB  out  1  shadow write enables.
- mem_read_EXE  out  1  EXE instruction is a load.
- stall_cycles  out  CNT_W  saturating count of stall cycles.

Behaviour:

Reset (rst_n=0, asynchronous):
- All shadow dest registers = 0, all shadow wb_en = 0, mem_read_EXE = 0.
- stall_cycles = 0.
- Combinational outputs follow from the cleared state.

Match rule:
- hit(s, use, d, en) = use && en && (s == d) && !(ZERO_REG_HARDWIRED && s == 0).
- hz_EXE = hit(src1_ID, use_src1_ID, dest_EXE, wb_en_EXE) OR the same test with src2.
- hz_MEM is defined the same way against the MEM shadow stage.
- The WB stage never hazards: the register file is write-before-read.

Outputs:
- stall_ID (combinational) = issue_valid_ID && !flush && (forward_en ? (hz_EXE && mem_read_EXE) : (hz_EXE || hz_MEM)).
- bubble_EXE = stall_ID || flush.
- freeze = !mem_ready. freeze is independent of stall_ID; both may be high together.

Shadow pipeline update:
- When freeze=1, all shadow registers and stall_cycles hold.
- Otherwise, EXE loads {dest_ID, wb_en_ID, mem_read_ID} when issue_valid_ID && !bubble_EXE. Else EXE loads a bubble {0, 0, 0}.
- MEM <= EXE and WB <= MEM, every unfrozen cycle.

Latency:
- A load issued at cycle t is in EXE at t+1.
- A dependent instruction in ID at t+1 stalls exactly one cycle with forwarding on.
- With forwarding off, a dependent in ID directly behind any writer stalls 2 cycles.

Boundary conditions:
- flush and a hazard in the same cycle: flush wins, so stall_ID=0 and bubble_EXE=1.
- Hazard on both src1 and src2: the cycle count equals the single-hazard case.
- A bubble is never treated as a writer, because its wb_en=0.
- stall_cycles increments when stall_ID && !freeze, and saturates at all-ones.
- Reset mid-stall: stall_ID drops immediately, because the shadow is cleared asynchronously.
- When issue_valid_ID=0, stall_ID=0.

Test Plan:
- Reset then idle: dest_* = 0, wb_en_* = 0, stall_ID = 0, stall_cycles = 0.
- Load-use with forward_en=1:
  - Stimulus: issue LDR dest=3, then ADD with src1=3 held in ID.
  - Required: stall_ID=1 and bubble_EXE=1 for exactly 1 cycle, then 0.
  - Required: after the stall, dest_MEM=3 and wb_en_EXE=0 (the bubble). stall_cycles=1.
- ALU RAW with forward_en=1:
  - Stimulus: ADD dest=5, then SUB with src2=5.
  - Required: stall_ID=0. Next cycle dest_MEM=5, wb_en_MEM=1.
- Same ALU RAW with forward_en=0:
  - Required: stall_ID=1 for 2 cycles. Released when dest_WB=5. stall_cycles=2.
- Freeze:
  - Stimulus: mem_ready=0 for 3 cycles during a load-use stall.
  - Required: freeze=1 and all shadow registers hold.
  - Required: stall_cycles does not increment. The stall resolves after mem_ready returns.
- Flush vs hazard, plus corner cases:
  - flush=1 with a load-use hazard present: stall_ID=0, bubble_EXE=1, EXE becomes a bubble.
  - ZERO_REG_HARDWIRED=1 with src1=0 against dest_EXE=0, wb_en_EXE=1: no stall.
  - With CNT_W=2, continuous stalls: stall_cycles saturates at 3.
